// File: rtl/conv2d_filter_out_scheduler_pkg.sv
// Shared definitions for the conv2d_1 output scheduler.
//   state_e    : scheduler FSM encoding (IDLE, RUN, DONE)
//   idx_width  : bit width of a lane index for n lanes
//   cnt_width  : bit width of a counter that must reach 'total'
package conv2d_filter_out_scheduler_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/conv2d_filter_out_scheduler_lane_fifo.sv
// Per-lane result buffer: DEPTH-word synchronous FIFO with occupancy count.
//   clear        : synchronous flush (pointers and count to zero)
//   push / wdata : write a word (caller guarantees count < DEPTH)
//   pop          : retire the head word (caller guarantees count > 0)
//   head         : word at the read pointer
//   count        : current occupancy, 0..DEPTH
module conv2d_filter_out_scheduler_lane_fifo
  import conv2d_filter_out_scheduler_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DWIDTH-1:0]          wdata,
  output logic [DWIDTH-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/conv2d_filter_out_scheduler.sv
// Output scheduler for the conv2d_1 feature-map stage.
// Buffers each filter core's results in its own lane and drains the lanes in
// strict filter order into one downstream write FIFO, one feature map per start.
//   start            : begin a feature map (IDLE only)
//   in_data/in_valid : per-filter result words, lane i at [i*DWIDTH +: DWIDTH]
//   hold             : per-filter stall request
//   ff_wdata/ff_wrreq: downstream write port, blocked by ff_full
//   busy/done        : map in progress / one-cycle completion pulse
//   overflow         : sticky, a word arrived for a full lane
module conv2d_filter_out_scheduler
  import conv2d_filter_out_scheduler_pkg::*;
#(
  parameter int unsigned DWIDTH      = DWIDTH_DEFAULT,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SLACK       = 2,
  parameter int unsigned PIXELS      = 900
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_FILTERS*DWIDTH-1:0]   in_data,
  input  logic [NUM_FILTERS-1:0]          in_valid,
  output logic [NUM_FILTERS-1:0]          hold,
  output logic [DWIDTH-1:0]               ff_wdata,
  output logic                            ff_wrreq,
  input  logic                            ff_full,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int unsigned TOTAL = PIXELS * NUM_FILTERS;
  localparam int unsigned PW    = idx_width(NUM_FILTERS);
  localparam int unsigned CW    = cnt_width(TOTAL);
  localparam int unsigned LCW   = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;

  logic                   run;
  logic                   clear;
  logic [NUM_FILTERS-1:0] push;
  logic [NUM_FILTERS-1:0] pop;
  logic [NUM_FILTERS-1:0] lane_full;
  logic [DWIDTH-1:0]      head   [NUM_FILTERS];
  logic [LCW-1:0]         lcount [NUM_FILTERS];

  assign run   = (state_q == ST_RUN);
  assign clear = (state_q == ST_IDLE) && start;

  // One buffer per filter core; only the pointer lane is ever popped.
  for (genvar g = 0; g < int'(NUM_FILTERS); g++) begin : g_lane
    assign lane_full[g] = (lcount[g] == LCW'(DEPTH));
    assign push[g]      = run && in_valid[g] && !lane_full[g];
    assign pop[g]       = ff_wrreq && (ptr_q == PW'(g));
    assign hold[g]      = !run || (lcount[g] >= LCW'(DEPTH - SLACK));

    conv2d_filter_out_scheduler_lane_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (in_data[g*DWIDTH +: DWIDTH]),
      .head  (head[g]),
      .count (lcount[g])
    );
  end

  // Write only from the pointer lane; an empty pointer lane stalls the stream.
  assign ff_wrreq = run && !ff_full && (lcount[ptr_q] != '0);
  assign ff_wdata = ff_wrreq ? head[ptr_q] : wdata_q;

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign overflow = ovf_q;

  // FSM, round-robin pointer, write counter and last-word hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q || (run && |(in_valid & lane_full));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          wcnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (ff_wrreq) begin
          wdata_d = head[ptr_q];
          ptr_d   = (ptr_q == PW'(NUM_FILTERS - 1)) ? '0 : ptr_q + PW'(1);
          wcnt_d  = wcnt_q + CW'(1);
          // Terminal count ends the map on the same edge as the last write.
          if (wcnt_q == CW'(TOTAL - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_conv2d_filter_out_scheduler.sv
// Directed bench for conv2d_filter_out_scheduler with PIXELS=2, NUM_FILTERS=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_conv2d_filter_out_scheduler;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   hold;
  logic [31:0]  ff_wdata;
  logic         ff_wrreq;
  logic         ff_full;
  logic         busy;
  logic         done;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] wq [$];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        st;
    logic [3:0]  v;
    logic [31:0] base;
    logic        full;
    logic        exp_wr;
    logic [31:0] exp_wd;
    logic        exp_busy;
    logic        exp_done;
    logic [3:0]  exp_hold;
  } vec_t;

  vec_t tbl [12];

  conv2d_filter_out_scheduler #(
    .DWIDTH      (32),
    .NUM_FILTERS (4),
    .DEPTH       (4),
    .SLACK       (2),
    .PIXELS      (2)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .hold     (hold),
    .ff_wdata (ff_wdata),
    .ff_wrreq (ff_wrreq),
    .ff_full  (ff_full),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then record writes/done.
  task automatic step(input logic st, input logic [3:0] v, input logic [31:0] base,
                      input logic full);
    @(negedge clk);
    start    = st;
    in_valid = v;
    ff_full  = full;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
    #1;
    if (ff_wrreq) wq.push_back(ff_wdata);
    if (done) done_cnt++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0;
    in_valid = '0;
    in_data = '0;
    ff_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    done_cnt = 0;
  endtask

  // Idle-drive until the map has completed and busy has dropped (bounded).
  task automatic run_to_idle(input string name);
    int n;
    n = 0;
    while (!(done_cnt > 0 && busy == 1'b0) && n < 100) begin
      step(1'b0, 4'h0, 32'h0, 1'b0);
      n++;
    end
    chk({name, "_terminated"}, 32'(n < 100), 32'd1);
  endtask

  task automatic chk_stream(input string name);
    chk({name, "_len"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wq.size()) chk($sformatf("%s_w%0d", name, i), wq[i], exp_q[i]);
    end
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    // st, v, base, full | wr, wdata, busy, done, hold
    tbl[0]  = '{1'b1, 4'h0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'hF};
    tbl[1]  = '{1'b0, 4'hF, 32'hF0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 32'hF8, 1'b0, 1'b1, 32'hF0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hF1, 1'b1, 1'b0, 4'hE};
    tbl[4]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hF2, 1'b1, 1'b0, 4'hC};
    tbl[5]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hF3, 1'b1, 1'b0, 4'h8};
    tbl[6]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hF8, 1'b1, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hF9, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hFA, 1'b1, 1'b0, 4'h0};
    tbl[9]  = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b1, 32'hFB, 1'b1, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b0, 32'hFB, 1'b1, 1'b1, 4'hF};
    tbl[11] = '{1'b0, 4'h0, 32'h00, 1'b0, 1'b0, 32'hFB, 1'b0, 1'b0, 4'hF};

    // Basic map: all filters in lockstep, no back-pressure.
    reset_dut();
    #1;
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_wdata", ff_wdata, 32'h0);
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].st, tbl[k].v, tbl[k].base, tbl[k].full);
      chk($sformatf("t%0d_wrreq", k), 32'(ff_wrreq), 32'(tbl[k].exp_wr));
      chk($sformatf("t%0d_wdata", k), ff_wdata, tbl[k].exp_wd);
      chk($sformatf("t%0d_busy", k), 32'(busy), 32'(tbl[k].exp_busy));
      chk($sformatf("t%0d_done", k), 32'(done), 32'(tbl[k].exp_done));
      chk($sformatf("t%0d_hold", k), 32'(hold), 32'(tbl[k].exp_hold));
    end

    // Filter 2 late: stream stalls after lane 1 and keeps filter order.
    reset_dut();
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'hB, 32'h20, 1'b0);
    step(1'b0, 4'hB, 32'h28, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("late_hold_a", 32'(hold), 32'hA);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("late_hold_b", 32'(hold), 32'h8);
    chk("late_stall_wrreq", 32'(ff_wrreq), 32'd0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("late_stall_count", 32'(wq.size()), 32'd2);
    step(1'b0, 4'h4, 32'h20, 1'b0);
    step(1'b0, 4'h4, 32'h28, 1'b0);
    run_to_idle("late");
    exp_q = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h28, 32'h29, 32'h2A, 32'h2B};
    chk_stream("late");

    // Back-pressure for 10 cycles mid-map.
    reset_dut();
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'hF, 32'h30, 1'b0);
    step(1'b0, 4'hF, 32'h38, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    begin
      int wr_seen;
      wr_seen = 0;
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 4'h0, 32'h0, 1'b1);
        if (ff_wrreq) wr_seen++;
      end
      chk("full_no_wrreq", 32'(wr_seen), 32'd0);
      chk("full_no_done", 32'(done_cnt), 32'd0);
    end
    run_to_idle("full");
    exp_q = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h38, 32'h39, 32'h3A, 32'h3B};
    chk_stream("full");

    // Lane 0 overflow: fifth word dropped, flag sticky across start.
    reset_dut();
    step(1'b1, 4'h0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'h1, 32'h40 + 32'(k), 1'b1);
    chk("ovf_before", 32'(overflow), 32'd0);
    chk("ovf_hold0", 32'(hold[0]), 32'd1);
    step(1'b0, 4'hE, 32'h50, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 4'hE, 32'h58, 1'b0);
    run_to_idle("ovf");
    exp_q = '{32'h40, 32'h51, 32'h52, 32'h53, 32'h41, 32'h59, 32'h5A, 32'h5B};
    chk_stream("ovf");
    chk("ovf_idle", 32'(overflow), 32'd1);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("ovf_restart_busy", 32'(busy), 32'd1);
    chk("ovf_restart_sticky", 32'(overflow), 32'd1);
    chk("ovf_restart_flushed", 32'(ff_wrreq), 32'd0);

    // Asynchronous reset between edges mid-map, then a clean map.
    step(1'b0, 4'hF, 32'h60, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("arst_pre_wdata", ff_wdata, 32'h60);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold", 32'(hold), 32'hF);
    chk("arst_wrreq", 32'(ff_wrreq), 32'd0);
    chk("arst_wdata", ff_wdata, 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    #1 rst = 1'b0;
    wq.delete();
    done_cnt = 0;
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'hF, 32'h70, 1'b0);
    step(1'b0, 4'hF, 32'h78, 1'b0);
    run_to_idle("arst");
    exp_q = '{32'h70, 32'h71, 32'h72, 32'h73, 32'h78, 32'h79, 32'h7A, 32'h7B};
    chk_stream("arst");

    // start during RUN is ignored; exactly one done.
    reset_dut();
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'hF, 32'h80, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'hF, 32'h88, 1'b0);
    run_to_idle("restart");
    for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 32'h0, 1'b0);
    exp_q = '{32'h80, 32'h81, 32'h82, 32'h83, 32'h88, 32'h89, 32'h8A, 32'h8B};
    chk_stream("restart");
    chk("restart_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
